// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-entry pipeline buffer with valid/ready on both sides and a synchronous flush.
// Optional stall/transfer statistics counters are enabled with PIPE_STAGE_BUFFER_STATS_EN.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [CNT_W-1:0]             xfer_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Handshake outputs come straight from registered occupancy, so no ready path is combinational.
  assign in_ready  = (r_count != OCC_FULL);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally left unreset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= in_data;
  end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_xfer_count;

  // Saturating counters; flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_xfer_count   <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      if (w_pop && !flush && (r_xfer_count != '1))
        r_xfer_count <= r_xfer_count + CNT_ONE;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign xfer_count   = r_xfer_count;
`else
  assign stall_cycles = '0;
  assign xfer_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a DEPTH=4 instance and a DEPTH=2/CNT_W=4 instance,
// each checked every cycle against a queue-based scoreboard and occupancy/statistics model.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: DEPTH=4, CNT_W=16
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;
  logic [15:0] a_stall, a_xfer;

  // Instance B: DEPTH=2, CNT_W=4
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  logic [3:0]  b_stall, b_xfer;

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .stall_cycles(a_stall), .xfer_count(a_xfer)
  );

  pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .stall_cycles(b_stall), .xfer_count(b_xfer)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int m_stall_a, m_xfer_a, m_stall_b, m_xfer_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check_state();
    chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, qa.size() != 0});
    chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, qa.size() != 4});
    chk("a_count",     {29'd0, a_count},     32'(qa.size()));
    if (qa.size() != 0) chk("a_out_data", a_out_data, qa[0]);
    chk("a_stall", {16'd0, a_stall}, stat_exp(m_stall_a));
    chk("a_xfer",  {16'd0, a_xfer},  stat_exp(m_xfer_a));
    chk("b_out_valid", {31'd0, b_out_valid}, {31'd0, qb.size() != 0});
    chk("b_in_ready",  {31'd0, b_in_ready},  {31'd0, qb.size() != 2});
    chk("b_count",     {30'd0, b_count},     32'(qb.size()));
    if (qb.size() != 0) chk("b_out_data", b_out_data, qb[0]);
    chk("b_stall", {28'd0, b_stall}, stat_exp(m_stall_b));
    chk("b_xfer",  {28'd0, b_xfer},  stat_exp(m_xfer_b));
  endtask

  // Check current outputs, advance the scoreboard for this edge, then step one clock.
  task automatic tick();
    bit pa, pua, pb, pub;
    check_state();
    pa  = a_out_ready && (qa.size() != 0);
    pua = a_in_valid  && (qa.size() != 4);
    if (qa.size() != 0 && !a_out_ready && m_stall_a < 65535) m_stall_a++;
    if (pa && !a_flush && m_xfer_a < 65535) m_xfer_a++;
    if (a_flush) qa.delete();
    else begin
      if (pa)  void'(qa.pop_front());
      if (pua) qa.push_back(a_in_data);
    end
    pb  = b_out_ready && (qb.size() != 0);
    pub = b_in_valid  && (qb.size() != 2);
    if (qb.size() != 0 && !b_out_ready && m_stall_b < 15) m_stall_b++;
    if (pb && !b_flush && m_xfer_b < 15) m_xfer_b++;
    if (b_flush) qb.delete();
    else begin
      if (pb)  void'(qb.pop_front());
      if (pub) qb.push_back(b_in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_stall_a = 0; m_xfer_a = 0; m_stall_b = 0; m_xfer_b = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    model_reset();
    #1;
    check_state();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push then drain
    a_in_valid = 1; a_in_data = 32'hA5A5_0001; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    chk("single_valid", {31'd0, a_out_valid}, 32'd1);
    chk("single_data",  a_out_data, 32'hA5A5_0001);
    tick();
    chk("single_empty", {29'd0, a_count}, 32'd0);
    tick();

    // Fill to full with a fifth payload waiting upstream
    a_out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1; a_in_data = 32'(i);
      tick();
    end
    a_in_data = 32'd5;
    chk("full_ready", {31'd0, a_in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("full_held", a_out_data, 32'd1);
    a_out_ready = 1;
    tick();
    chk("ready_after_pop", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 5; i++) tick();

    // Streaming 100 payloads
    for (int i = 0; i < 100; i++) begin
      a_in_valid = 1; a_in_data = 32'h1000 + 32'(i);
      tick();
      chk("stream_count", {29'd0, a_count}, 32'd1);
    end
    a_in_valid = 0;
    tick();
    tick();

    // Flush with simultaneous push and pop at count=3
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1; a_in_data = 32'h2000 + 32'(i);
      tick();
    end
    a_flush = 1; a_in_valid = 1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("flush_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush_ready", {31'd0, a_in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) tick();

    // Alternating push/pop across pointer wrap on DEPTH=2
    for (int i = 0; i < 7; i++) begin
      b_in_valid = 1; b_in_data = 32'h3000 + 32'(i); b_out_ready = 0;
      tick();
      b_in_valid = 0; b_out_ready = 1;
      chk("wrap_data", b_out_data, 32'h3000 + 32'(i));
      tick();
    end
    tick();

    // Mid-cycle async reset with count=2
    b_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      b_in_valid = 1; b_in_data = 32'h4000 + 32'(i);
      tick();
    end
    b_in_valid = 0;
    check_state();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", {30'd0, b_count}, 32'd0);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stall counter saturation on CNT_W=4
    b_in_valid = 1; b_in_data = 32'h5000; b_out_ready = 0;
    tick();
    b_in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    chk("sat_stall", {28'd0, b_stall}, 32'd15);
`else
    chk("sat_stall", {28'd0, b_stall}, 32'd0);
`endif
    b_out_ready = 1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
